// File: rtl/arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Optional round-robin fairness is selected with MEM_ARBITER_RR_EN (tested only in arb_grant).
package arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP
  } stateT;

  typedef enum logic {
    INST,
    DATA
  } ownerT;

endpackage

// File: rtl/arb_grant.sv
// Grant selection between the instruction and data ports.
// MEM_ARBITER_RR_EN defined: simultaneous requests go to the port not granted last.
// MEM_ARBITER_RR_EN undefined: the data port always wins a collision.
module arb_grant
  import arb_pkg::*;
(
  input  logic  inst_req,
  input  logic  data_req,
  input  ownerT last_grant,
  output ownerT winner
);

`ifdef MEM_ARBITER_RR_EN

  // Round-robin pick: on a collision hand the bus to whoever was not served last.
  always_comb begin
    winner = DATA;
    if (inst_req && data_req) begin
      winner = (last_grant == INST) ? DATA : INST;
    end else if (inst_req) begin
      winner = INST;
    end
  end

`else

  // Fixed priority has no use for the history, so it is deliberately left dangling.
  logic unusedLastGrant;
  assign unusedLastGrant = (last_grant == DATA);

  // Fixed priority pick: data wins unless only the instruction port is asking.
  always_comb begin
    winner = DATA;
    if (inst_req && !data_req) begin
      winner = INST;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one bus master port between the instruction fetch and data ports.
// One transaction at a time: IDLE -> ADDR -> WAIT -> RESP -> IDLE.
// Fairness mode is chosen by MEM_ARBITER_RR_EN inside arb_grant; the owner
// register doubles as the "last granted" history, so no extra state exists.
module mem_arbiter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  // instruction port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [STRB_W-1:0] data_wstrb,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  // bus master port
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [STRB_W-1:0] bus_wstrb,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  // pipeline stalls
  output logic              stall_inst,
  output logic              stall_data
);

  stateT             state;
  stateT             nextState;
  ownerT             owner;
  ownerT             winner;
  logic              anyReq;
  logic              captureRdata;
  logic [ADDR_W-1:0] addrReg;
  logic              wrReg;
  logic [DATA_W-1:0] wdataReg;
  logic [STRB_W-1:0] wstrbReg;
  logic [DATA_W-1:0] instRdataReg;
  logic [DATA_W-1:0] dataRdataReg;

  assign anyReq = inst_req | data_req;

  arb_grant uGrant (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (owner),
    .winner     (winner)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; handshakes are only honoured in the states that expect them.
  always_comb begin
    nextState    = state;
    captureRdata = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          nextState = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            nextState    = RESP;
            captureRdata = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          nextState    = RESP;
          captureRdata = 1'b1;
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Latch the winner's request on grant so the bus sees stable values even if the requester lets go.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner    <= INST;
      addrReg  <= '0;
      wrReg    <= 1'b0;
      wdataReg <= '0;
      wstrbReg <= '0;
    end else if (state == IDLE && anyReq) begin
      owner <= winner;
      if (winner == DATA) begin
        addrReg  <= data_addr;
        wrReg    <= data_wr;
        wdataReg <= data_wdata;
        wstrbReg <= data_wstrb;
      end else begin
        addrReg  <= inst_addr;
        wrReg    <= 1'b0;
        wdataReg <= '0;
        wstrbReg <= '0;
      end
    end
  end

  // Capture returned read data into the owning port; stores keep the previous load value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instRdataReg <= '0;
      dataRdataReg <= '0;
    end else if (captureRdata) begin
      if (owner == INST) begin
        instRdataReg <= bus_rdata;
      end else if (!wrReg) begin
        dataRdataReg <= bus_rdata;
      end
    end
  end

  assign bus_req    = (state == ADDR);
  assign bus_wr     = wrReg;
  assign bus_addr   = addrReg;
  assign bus_wdata  = wdataReg;
  assign bus_wstrb  = wstrbReg;

  assign inst_ready = (state == RESP) && (owner == INST);
  assign data_ready = (state == RESP) && (owner == DATA);
  assign inst_rdata = instRdataReg;
  assign data_rdata = dataRdataReg;

  assign stall_inst = inst_req & ~inst_ready;
  assign stall_data = data_req & ~data_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
// Build with MEM_ARBITER_RR_EN defined to exercise round-robin fairness.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stall_inst;
  logic        stall_data;

  int assertCount = 0;
  int failCount   = 0;

  // transaction-level model state (port 0 = instruction, 1 = data)
  int          cyc;
  bit          busy;
  int          tOwner;
  logic [31:0] tAddr;
  logic        tWr;
  logic [31:0] tWdata;
  logic [3:0]  tWstrb;
  logic [31:0] tRdata;
  int          grantCyc;
  int          addrOkCyc;
  int          dataOkCyc;
  int          lastGrant;
  logic [31:0] mInstRdata;
  logic [31:0] mDataRdata;
  bit          instActive;
  bit          dataActive;
  bit          instDropped;
  bit          dataDropped;

  mem_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_ready  (inst_ready),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_wstrb  (data_wstrb),
    .data_rdata  (data_rdata),
    .data_ready  (data_ready),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .stall_inst  (stall_inst),
    .stall_data  (stall_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_addr   = '0;
    data_wdata  = '0;
    data_wstrb  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  task automatic applyReset();
    resetn = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // One cycle of randomized requesters and bus slave, plus the model's view of that cycle.
  task automatic applyStimulus();
    int winner;
    bit idleOrResp;
    cyc++;
    if (busy && cyc == dataOkCyc + 1) begin
      if (tOwner == 0) mInstRdata = tRdata;
      else if (!tWr) mDataRdata = tRdata;
    end
    if (busy && cyc == dataOkCyc + 2) begin
      busy = 1'b0;
      if (tOwner == 0) instActive = 1'b0;
      else dataActive = 1'b0;
    end
    // instruction requester
    if (!instActive && $urandom_range(0, 2) == 0) begin
      instActive  = 1'b1;
      instDropped = 1'b0;
      inst_addr   = $urandom;
    end else if (!instActive) begin
      inst_addr = $urandom;
    end else if (busy && tOwner == 0 && cyc > grantCyc && !instDropped && $urandom_range(0, 15) == 0) begin
      instDropped = 1'b1;
    end
    inst_req = instActive && !instDropped;
    // data requester
    if (!dataActive && $urandom_range(0, 2) == 0) begin
      dataActive  = 1'b1;
      dataDropped = 1'b0;
      data_wr     = 1'($urandom_range(0, 1));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      data_wstrb  = 4'($urandom);
    end else if (!dataActive) begin
      data_wr    = 1'($urandom_range(0, 1));
      data_addr  = $urandom;
      data_wdata = $urandom;
      data_wstrb = 4'($urandom);
    end else if (busy && tOwner == 1 && cyc > grantCyc && !dataDropped && $urandom_range(0, 15) == 0) begin
      dataDropped = 1'b1;
    end
    data_req = dataActive && !dataDropped;
    // grant decision on an idle bus
    if (!busy && (inst_req || data_req)) begin
      if (inst_req && data_req) begin
`ifdef MEM_ARBITER_RR_EN
        winner = (lastGrant == 0) ? 1 : 0;
`else
        winner = 1;
`endif
      end else begin
        winner = data_req ? 1 : 0;
      end
      busy      = 1'b1;
      tOwner    = winner;
      lastGrant = winner;
      if (winner == 1) begin
        tAddr  = data_addr;
        tWr    = data_wr;
        tWdata = data_wdata;
        tWstrb = data_wstrb;
      end else begin
        tAddr  = inst_addr;
        tWr    = 1'b0;
        tWdata = '0;
        tWstrb = '0;
      end
      grantCyc  = cyc;
      addrOkCyc = cyc + 1 + int'($urandom_range(0, 6));
      dataOkCyc = addrOkCyc + int'($urandom_range(0, 4));
    end
    // bus slave following the planned schedule, plus ignorable noise
    bus_rdata   = $urandom;
    bus_addr_ok = busy && cyc == addrOkCyc;
    bus_data_ok = busy && cyc == dataOkCyc;
    if (busy && cyc == dataOkCyc) tRdata = bus_rdata;
    idleOrResp = !busy || cyc == grantCyc || cyc == dataOkCyc + 1;
    if (idleOrResp) begin
      if ($urandom_range(0, 3) == 0) bus_addr_ok = 1'b1;
      if ($urandom_range(0, 3) == 0) bus_data_ok = 1'b1;
    end else if (cyc > addrOkCyc && cyc < dataOkCyc) begin
      if ($urandom_range(0, 3) == 0) bus_addr_ok = 1'b1;
    end
  endtask

  // Compare every observable output against the model for the current cycle.
  task automatic compareModel();
    bit expBusReq;
    bit expInstReady;
    bit expDataReady;
    expBusReq    = busy && cyc > grantCyc && cyc <= addrOkCyc;
    expInstReady = busy && cyc == dataOkCyc + 1 && tOwner == 0;
    expDataReady = busy && cyc == dataOkCyc + 1 && tOwner == 1;
    checkOutput("rnd bus_req", 32'(bus_req), 32'(expBusReq));
    checkOutput("rnd inst_ready", 32'(inst_ready), 32'(expInstReady));
    checkOutput("rnd data_ready", 32'(data_ready), 32'(expDataReady));
    checkOutput("rnd inst_rdata", inst_rdata, mInstRdata);
    checkOutput("rnd data_rdata", data_rdata, mDataRdata);
    checkOutput("rnd stall_inst", 32'(stall_inst), 32'(inst_req && !expInstReady));
    checkOutput("rnd stall_data", 32'(stall_data), 32'(data_req && !expDataReady));
    if (expBusReq) begin
      checkOutput("rnd bus_addr", bus_addr, tAddr);
      checkOutput("rnd bus_wr", 32'(bus_wr), 32'(tWr));
      checkOutput("rnd bus_wdata", bus_wdata, tWdata);
      checkOutput("rnd bus_wstrb", 32'(bus_wstrb), 32'(tWstrb));
    end
  endtask

  initial begin
    logic [31:0] secondAddr;
    logic [31:0] thirdAddr;
    bit          secondIsInst;
    logic [31:0] expInstRdata;
    logic [31:0] expDataRdata;

`ifdef MEM_ARBITER_RR_EN
    secondAddr   = 32'h0000_1000;
    thirdAddr    = 32'h0000_3000;
    secondIsInst = 1'b1;
`else
    secondAddr   = 32'h0000_3000;
    thirdAddr    = 32'h0000_1000;
    secondIsInst = 1'b0;
`endif
    expInstRdata = secondIsInst ? 32'h0000_AAAA : 32'h0000_5555;
    expDataRdata = secondIsInst ? 32'h0000_5555 : 32'h0000_AAAA;

    // reset values while resetn is held low
    resetn = 1'b0;
    clearInputs();
    #12;
    checkOutput("reset bus_req", 32'(bus_req), 32'h0);
    checkOutput("reset bus_wr", 32'(bus_wr), 32'h0);
    checkOutput("reset bus_addr", bus_addr, 32'h0);
    checkOutput("reset bus_wdata", bus_wdata, 32'h0);
    checkOutput("reset bus_wstrb", 32'(bus_wstrb), 32'h0);
    checkOutput("reset inst_rdata", inst_rdata, 32'h0);
    checkOutput("reset data_rdata", data_rdata, 32'h0);
    checkOutput("reset inst_ready", 32'(inst_ready), 32'h0);
    checkOutput("reset data_ready", 32'(data_ready), 32'h0);

    // single fetch, granted on the first edge after reset release
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'hBFC0_0000;
    #2;
    checkOutput("fetch c0 stall_inst", 32'(stall_inst), 32'h1);
    checkOutput("fetch c0 bus_req", 32'(bus_req), 32'h0);
    nextCycle();
    bus_addr_ok = 1'b1;
    #2;
    checkOutput("fetch c1 bus_req", 32'(bus_req), 32'h1);
    checkOutput("fetch c1 bus_addr", bus_addr, 32'hBFC0_0000);
    checkOutput("fetch c1 bus_wr", 32'(bus_wr), 32'h0);
    checkOutput("fetch c1 stall_inst", 32'(stall_inst), 32'h1);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h2408_0001;
    #2;
    checkOutput("fetch c2 bus_req", 32'(bus_req), 32'h0);
    checkOutput("fetch c2 inst_ready", 32'(inst_ready), 32'h0);
    checkOutput("fetch c2 stall_inst", 32'(stall_inst), 32'h1);
    nextCycle();
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
    #2;
    checkOutput("fetch c3 inst_ready", 32'(inst_ready), 32'h1);
    checkOutput("fetch c3 inst_rdata", inst_rdata, 32'h2408_0001);
    checkOutput("fetch c3 stall_inst", 32'(stall_inst), 32'h0);
    checkOutput("fetch c3 data_ready", 32'(data_ready), 32'h0);
    nextCycle();
    inst_req = 1'b0;
    #2;
    checkOutput("fetch c4 inst_ready", 32'(inst_ready), 32'h0);

    // slow store: addr_ok after 5 extra cycles, data_ok 3 cycles later
    nextCycle();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF;
    data_wstrb = 4'hF;
    #2;
    checkOutput("store c0 stall_data", 32'(stall_data), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      bus_addr_ok = (k == 6);
      #2;
      checkOutput("store bus_req", 32'(bus_req), 32'h1);
      checkOutput("store bus_wr", 32'(bus_wr), 32'h1);
      checkOutput("store bus_addr", bus_addr, 32'h8000_0010);
      checkOutput("store bus_wdata", bus_wdata, 32'hDEAD_BEEF);
      checkOutput("store bus_wstrb", 32'(bus_wstrb), 32'hF);
    end
    for (int k = 7; k <= 9; k++) begin
      nextCycle();
      bus_addr_ok = 1'b0;
      bus_data_ok = (k == 9);
      bus_rdata   = 32'h1234_5678;
      #2;
      checkOutput("store wait bus_req", 32'(bus_req), 32'h0);
      checkOutput("store wait data_ready", 32'(data_ready), 32'h0);
    end
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #2;
    checkOutput("store c10 data_ready", 32'(data_ready), 32'h1);
    checkOutput("store c10 data_rdata", data_rdata, 32'h0);
    checkOutput("store c10 stall_data", 32'(stall_data), 32'h0);
    nextCycle();
    data_req = 1'b0;
    data_wr  = 1'b0;
    #2;
    checkOutput("store c11 data_ready", 32'(data_ready), 32'h0);
    checkOutput("store c11 bus_req", 32'(bus_req), 32'h0);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("store c12 bus_req", 32'(bus_req), 32'h0);
    checkOutput("store c12 inst_ready", 32'(inst_ready), 32'h0);
    checkOutput("store c12 data_ready", 32'(data_ready), 32'h0);

    // addr_ok and data_ok together: ready at cycle 2
    nextCycle();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hCAFE_F00D;
    #2;
    checkOutput("fast c1 bus_req", 32'(bus_req), 32'h1);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("fast c2 inst_ready", 32'(inst_ready), 32'h1);
    checkOutput("fast c2 inst_rdata", inst_rdata, 32'hCAFE_F00D);
    nextCycle();
    inst_req = 1'b0;

    // collision, then the served data port re-requests while inst still waits
    applyReset();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_1000;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_2000;
    #2;
    checkOutput("coll c0 stall_inst", 32'(stall_inst), 32'h1);
    checkOutput("coll c0 stall_data", 32'(stall_data), 32'h1);
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_D001;
    #2;
    checkOutput("coll c1 bus_req", 32'(bus_req), 32'h1);
    checkOutput("coll c1 bus_addr", bus_addr, 32'h0000_2000);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("coll c2 data_ready", 32'(data_ready), 32'h1);
    checkOutput("coll c2 inst_ready", 32'(inst_ready), 32'h0);
    checkOutput("coll c2 data_rdata", data_rdata, 32'h0000_D001);
    checkOutput("coll c2 stall_inst", 32'(stall_inst), 32'h1);
    nextCycle();
    data_addr = 32'h0000_3000;
    #2;
    checkOutput("coll c3 data_ready", 32'(data_ready), 32'h0);
    checkOutput("coll c3 bus_req", 32'(bus_req), 32'h0);
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_AAAA;
    #2;
    checkOutput("coll c4 bus_addr", bus_addr, secondAddr);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("coll c5 inst_ready", 32'(inst_ready), 32'(secondIsInst));
    checkOutput("coll c5 data_ready", 32'(data_ready), 32'(!secondIsInst));
    nextCycle();
    if (secondIsInst) inst_req = 1'b0;
    else data_req = 1'b0;
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_5555;
    #2;
    checkOutput("coll c7 bus_addr", bus_addr, thirdAddr);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("coll c8 inst_ready", 32'(inst_ready), 32'(!secondIsInst));
    checkOutput("coll c8 inst_rdata", inst_rdata, expInstRdata);
    checkOutput("coll c8 data_rdata", data_rdata, expDataRdata);
    nextCycle();
    inst_req = 1'b0;
    data_req = 1'b0;

    // reset while waiting for data, then a clean transaction afterwards
    nextCycle();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_4000;
    nextCycle();
    bus_addr_ok = 1'b1;
    #2;
    checkOutput("rstwait c1 bus_req", 32'(bus_req), 32'h1);
    nextCycle();
    bus_addr_ok = 1'b0;
    #2;
    checkOutput("rstwait c2 bus_addr", bus_addr, 32'h0000_4000);
    resetn = 1'b0;
    #1;
    checkOutput("rstwait bus_req", 32'(bus_req), 32'h0);
    checkOutput("rstwait bus_addr", bus_addr, 32'h0);
    checkOutput("rstwait inst_ready", 32'(inst_ready), 32'h0);
    checkOutput("rstwait inst_rdata", inst_rdata, 32'h0);
    checkOutput("rstwait data_rdata", data_rdata, 32'h0);
    inst_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn    = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_5000;
    nextCycle();
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h0000_0077;
    #2;
    checkOutput("rstwait after bus_req", 32'(bus_req), 32'h1);
    checkOutput("rstwait after bus_addr", bus_addr, 32'h0000_5000);
    nextCycle();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    #2;
    checkOutput("rstwait after inst_ready", 32'(inst_ready), 32'h1);
    checkOutput("rstwait after inst_rdata", inst_rdata, 32'h0000_0077);
    nextCycle();
    inst_req = 1'b0;

    // randomized traffic against the transaction model
    applyReset();
    cyc         = -1;
    busy        = 1'b0;
    tOwner      = 0;
    lastGrant   = 0;
    grantCyc    = 0;
    addrOkCyc   = 0;
    dataOkCyc   = 0;
    tAddr       = '0;
    tWr         = 1'b0;
    tWdata      = '0;
    tWstrb      = '0;
    tRdata      = '0;
    mInstRdata  = '0;
    mDataRdata  = '0;
    instActive  = 1'b0;
    dataActive  = 1'b0;
    instDropped = 1'b0;
    dataDropped = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) nextCycle();
      applyStimulus();
      #2;
      compareModel();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
